instruction_fetch_unit: RTL

- Fetch stage between the program ROM and the instruction decoder of the 16-bit core.
- Drives the ROM address and assembles one- or two-word instructions (opcode word plus optional immediate or branch-target word).
- Presents each instruction to decode through a registered valid/ready handshake.
- Accepts a redirect (jump/branch/call/return target) from execute.

---
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the program ROM address, assembles one- or
// two-word instructions and hands them to decode over a registered
// valid/ready handshake. Execute may redirect fetch to a new PC at any time.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter logic [9:0]  IMM_SRC    = 10'h3A0,
    parameter logic [3:0]  BRANCH_NIB = 4'hE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic        has_imm,
    output logic [15:0] instr_pc
);

    localparam int unsigned W = 16;

    typedef enum logic {
        ST_OP  = 1'b0,
        ST_IMM = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   pc;
    logic [W-1:0]   pc_nxt;
    logic [W-1:0]   op_lat;
    logic [W-1:0]   op_lat_nxt;
    logic [W-1:0]   pc_lat;
    logic [W-1:0]   pc_lat_nxt;
    logic           valid_nxt;
    logic [W-1:0]   instr_nxt;
    logic [W-1:0]   imm_nxt;
    logic           has_imm_nxt;
    logic [W-1:0]   instr_pc_nxt;
    logic           adv;
    logic           two_word;

    // ROM is addressed straight from the PC; data returns in the same cycle.
    assign rom_addr = pc;

    // The output register may be reloaded when empty or being consumed.
    assign adv = !instr_valid || instr_ready;

    // An opcode word is followed by a second word for immediates and branches.
    assign two_word = (rom_data[9:0] == IMM_SRC) || (rom_data[15:12] == BRANCH_NIB);

    // State, PC, partial-op latch and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_OP;
            pc          <= RESET_ADDR;
            op_lat      <= '0;
            pc_lat      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            imm         <= '0;
            has_imm     <= 1'b0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            op_lat      <= op_lat_nxt;
            pc_lat      <= pc_lat_nxt;
            instr_valid <= valid_nxt;
            instr       <= instr_nxt;
            imm         <= imm_nxt;
            has_imm     <= has_imm_nxt;
            instr_pc    <= instr_pc_nxt;
        end
    end

    // Next-state and next-output logic; redirect overrides normal fetch.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        op_lat_nxt   = op_lat;
        pc_lat_nxt   = pc_lat;
        valid_nxt    = instr_valid;
        instr_nxt    = instr;
        imm_nxt      = imm;
        has_imm_nxt  = has_imm;
        instr_pc_nxt = instr_pc;

        if (redirect) begin
            // A same-cycle handshake has already completed; anything else is dropped.
            state_nxt = ST_OP;
            pc_nxt    = redirect_addr;
            valid_nxt = 1'b0;
        end else if (adv) begin
            unique case (state)
                ST_OP: begin
                    pc_nxt = pc + W'(1);
                    if (two_word) begin
                        op_lat_nxt = rom_data;
                        pc_lat_nxt = pc;
                        valid_nxt  = 1'b0;
                        state_nxt  = ST_IMM;
                    end else begin
                        valid_nxt    = 1'b1;
                        instr_nxt    = rom_data;
                        imm_nxt      = '0;
                        has_imm_nxt  = 1'b0;
                        instr_pc_nxt = pc;
                    end
                end
                ST_IMM: begin
                    pc_nxt       = pc + W'(1);
                    valid_nxt    = 1'b1;
                    instr_nxt    = op_lat;
                    imm_nxt      = rom_data;
                    has_imm_nxt  = 1'b1;
                    instr_pc_nxt = pc_lat;
                    state_nxt    = ST_OP;
                end
                default: begin
                    state_nxt = ST_OP;
                end
            endcase
        end
    end

endmodule
